// File: rtl/cond_sum_adder_pipe.sv
// Pipelined conditional-sum adder/subtractor with bubble-collapsing valid/ready stages.
// Define CSA_CHECK_EN to build the shadow pipeline and the behavioural result checker.
module cond_sum_adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             mismatch,
  output logic [15:0]      err_count
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int LVLS  = LOG2W + 1;

  // Per-level payload. Before level 0, s0/s1 carry the raw operands a and b'.
  // From level 0 on, s0/s1 are block sums for block carry-in 0/1 and c0/c1
  // are block carry-outs indexed by block number.
  typedef struct packed {
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] c0;
    logic [WIDTH-1:0] c1;
    logic             ce;
    logic             am;
    logic             bm;
    logic             ov;
`ifdef CSA_CHECK_EN
    logic [WIDTH-1:0] sx;
    logic [WIDTH-1:0] sy;
    logic             scin;
    logic             ssub;
`endif
  } stg_t;

  function automatic stg_t level_fn(input stg_t d, input int lvl);
    stg_t             r;
    logic [WIDTH-1:0] fs;
    logic             fc;
    r = d;
    if (lvl == 0) begin
      r.s0 = d.s0 ^ d.s1;
      r.s1 = ~(d.s0 ^ d.s1);
      r.c0 = d.s0 & d.s1;
      r.c1 = d.s0 | d.s1;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (((b >> (lvl - 1)) & 1) == 1) begin
          r.s0[b] = d.c0[(b >> lvl) << 1] ? d.s1[b] : d.s0[b];
          r.s1[b] = d.c1[(b >> lvl) << 1] ? d.s1[b] : d.s0[b];
        end
      end
      r.c0 = '0;
      r.c1 = '0;
      for (int j = 0; j < WIDTH / 2; j++) begin
        if (j < (WIDTH >> lvl)) begin
          r.c0[j] = d.c0[2*j] ? d.c1[2*j+1] : d.c0[2*j+1];
          r.c1[j] = d.c1[2*j] ? d.c1[2*j+1] : d.c0[2*j+1];
        end
      end
    end
    // The last level also applies the effective carry-in so outputs come straight from a register.
    if (lvl == LVLS - 1) begin
      fs   = d.ce ? r.s1 : r.s0;
      fc   = d.ce ? r.c1[0] : r.c0[0];
      r.s0 = fs;
      r.s1 = fs;
      r.c0 = {{(WIDTH-1){1'b0}}, fc};
      r.c1 = r.c0;
      r.ov = (d.am == d.bm) && (fs[WIDTH-1] != d.am);
    end
    return r;
  endfunction

  // Returns the register stage number placed after logic level lvl, or 0 for none.
  function automatic int reg_after(input int lvl);
    int hit;
    hit = 0;
    for (int k = 1; k <= STAGES; k++)
      if ((k * LVLS) / STAGES - 1 == lvl) hit = k;
    return hit;
  endfunction

  stg_t              w_lv_in  [LVLS];
  stg_t              w_lv_out [LVLS];
  stg_t              w_stg_d  [1:STAGES];
  stg_t              r_data   [1:STAGES];
  logic [STAGES:1]   r_vld;
  logic [STAGES:1]   w_ld;
  logic [STAGES:0]   w_vchain;
  logic [WIDTH-1:0]  w_b;

  always_comb begin
    w_b               = sub ? ~y : y;
    w_lv_in[0]        = '0;
    w_lv_in[0].s0     = x;
    w_lv_in[0].s1     = w_b;
    w_lv_in[0].ce     = sub | cin;
    w_lv_in[0].am     = x[WIDTH-1];
    w_lv_in[0].bm     = w_b[WIDTH-1];
`ifdef CSA_CHECK_EN
    w_lv_in[0].sx     = x;
    w_lv_in[0].sy     = y;
    w_lv_in[0].scin   = cin;
    w_lv_in[0].ssub   = sub;
`endif
  end

  genvar gl;
  for (gl = 0; gl < LVLS; gl++) begin : g_lvl
    localparam int K = reg_after(gl);
    assign w_lv_out[gl] = level_fn(w_lv_in[gl], gl);
    if (K != 0) begin : g_reg
      assign w_stg_d[K] = w_lv_out[gl];
    end
    if (gl < LVLS - 1) begin : g_link
      if (K != 0) begin : g_from_reg
        assign w_lv_in[gl+1] = r_data[K];
      end else begin : g_from_comb
        assign w_lv_in[gl+1] = w_lv_out[gl];
      end
    end
  end

  // Handshake: a beat moves on an edge where valid && ready. Stage k loads when
  // empty or when its own beat moves on; ready ripples back from out_ready only,
  // so in_ready never depends on in_valid.
  always_comb begin
    logic ld;
    ld = out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      ld      = !r_vld[k] || ld;
      w_ld[k] = ld;
    end
  end

  assign w_vchain = {r_vld, in_valid};
  assign in_ready = w_ld[1];

  always_ff @(posedge clk) begin
    for (int k = 1; k <= STAGES; k++) begin
      if (rst) begin
        r_vld[k]  <= 1'b0;
        r_data[k] <= '0;
      end else if (w_ld[k]) begin
        r_vld[k] <= w_vchain[k-1];
        if (w_vchain[k-1]) r_data[k] <= w_stg_d[k];
      end
    end
  end

  assign out_valid = r_vld[STAGES];
  assign sum       = r_data[STAGES].s0;
  assign cout      = r_data[STAGES].c0[0];
  assign ovf       = r_data[STAGES].ov;

`ifdef CSA_CHECK_EN
  logic [WIDTH:0] w_ref;
  logic           w_mis;
  logic [15:0]    r_err;
  stg_t           w_o;

  always_comb begin
    w_o   = r_data[STAGES];
    w_ref = {1'b0, w_o.sx} + {1'b0, (w_o.ssub ? ~w_o.sy : w_o.sy)}
          + {{WIDTH{1'b0}}, (w_o.ssub | w_o.scin)};
    w_mis = r_vld[STAGES] && ({cout, sum} != w_ref);
  end

  always_ff @(posedge clk) begin
    if (rst) r_err <= '0;
    else if (w_mis && out_ready && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
  end

  assign mismatch  = w_mis;
  assign err_count = r_err;
`else
  assign mismatch  = 1'b0;
  assign err_count = 16'd0;
`endif

endmodule
